plad_div_arbiter: RTL and testbench
===================================

// Module: plad_div_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one combinational PLAD approximate divider among NREQ requesters.
//  Latches the winning operand pair and drives it to the divider. Registers res/exp1 and returns them with the requester ID.
//  Handshake is valid/ready on both sides. Sits between the requester ports and the single divider instance.
// PARAMETERS
//  SIZE   16  operand/result width; must match the divider instance
//  NREQ   4   number of requesters, 2..16
//  IDW    2   ID width, = clog2(NREQ)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       per-requester request valid
//  req_x1     in   NREQ*SIZE  dividends; requester i uses bits [i*SIZE +: SIZE]
//  req_x2     in   NREQ*SIZE  divisors, packed the same way as req_x1
//  req_ready  out  NREQ       one-hot grant pulse; the request is accepted in this cycle
//  div_x1     out  SIZE       operand X1 to the divider (registered)
//  div_x2     out  SIZE       operand X2 to the divider (registered)
//  div_res    in   SIZE       divider result (combinational from div_x1/div_x2)
//  div_exp1   in   1          divider normalisation flag
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response accept
//  rsp_res    out  SIZE       quotient
//  rsp_exp1   out  1          normalisation flag
//  rsp_id     out  IDW        index of the requester that owns the response
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; rr_ptr=0.
//  FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//  IDLE:
//   - If any req_valid is set: grant = first set bit, searching circularly from rr_ptr.
//   - req_ready[grant]=1 for exactly one cycle (combinational in IDLE).
//   - Latch that requester's operands into div_x1/div_x2 and its index into id_q. Go to ISSUE.
//   - If no req_valid: stay in IDLE; req_ready=0.
//  ISSUE: one cycle for the divider inputs to settle; go to CAPTURE.
//  CAPTURE: register div_res -> rsp_res, div_exp1 -> rsp_exp1, id_q -> rsp_id; set rsp_valid=1; go to RESP.
//  RESP:
//   - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
//   - On rsp_ready=1: clear rsp_valid; rr_ptr = id_q+1 (wraps NREQ-1 -> 0); go to IDLE.
//  Latency: grant at cycle T -> rsp_valid at T+3. Minimum issue interval is 4 cycles (no overlap; one transaction in flight).
//  req_ready is 0 in every state except IDLE, so no new grant is made while a response is pending.
//  A requester may drop req_valid before it is granted; it is never granted without req_valid in the same cycle.
//  Simultaneous requests: exactly one grant. Fairness: every asserted requester is served within NREQ transactions.
//  div_x1/div_x2 keep their last operands after the transaction, which avoids needless divider toggling.
//  rsp_res/rsp_exp1/rsp_id keep their values after rsp_valid falls.
//  rst asserted in any state: next cycle everything is at reset values.
//   - An in-flight transaction is discarded; no response is issued.
//   - rr_ptr returns to 0.
//  No arithmetic is done here. X2==0 is passed through unchanged; the result is whatever the divider produces.
// CONFIGURATION
//  PLAD_ARB_PERF_CNT_EN defined:
//   - Adds output perf_cnt [31:0]: number of completed responses (rsp_valid & rsp_ready).
//   - Adds output stall_cnt [31:0]: cycles in RESP with rsp_ready=0.
//   - Both counters reset to 0, increment with the stated events, and saturate at 32'hFFFF_FFFF.
//  PLAD_ARB_PERF_CNT_EN undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: hold rst 2 cycles -> all outputs 0.
//    Release with req_valid=0 for 10 cycles -> req_ready stays 0 and rsp_valid stays 0.
//  2 Single request: req_valid=4'b0100, x1=16'h4000, x2=16'h4000, rsp_ready=1.
//    -> req_ready=4'b0100 at T. div_x1=div_x2=16'h4000 from T+1.
//    -> At T+3: rsp_valid=1, rsp_id=2, rsp_res equals the standalone divider's output for the same operands.
//  3 Round robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, each grant 4 cycles apart.
//  4 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
//    -> rsp_* stable throughout; req_ready=0 for all requesters; stall_cnt=5 when PLAD_ARB_PERF_CNT_EN is defined.
//  5 Reset mid-operation: assert rst in the ISSUE state.
//    -> No rsp_valid afterwards; after release, req_valid=4'b0011 grants requester 0 first.
//  6 Withdrawal: requester 1 raises req_valid while requester 0 is in RESP, then drops it before IDLE.
//    -> Requester 1 receives no grant and produces no response.

Source files
------------

// File: rtl/plad_div_arbiter_if.sv
// Handshake bundle between the requesters, the PLAD divider arbiter and the shared divider.
// master: arbiter side. slave: requester/divider side.
interface plad_div_arbiter_if #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_x1;
  logic [NREQ*SIZE-1:0] req_x2;
  logic [NREQ-1:0]      req_ready;

  logic [SIZE-1:0]      div_x1;
  logic [SIZE-1:0]      div_x2;
  logic [SIZE-1:0]      div_res;
  logic                 div_exp1;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [SIZE-1:0]      rsp_res;
  logic                 rsp_exp1;
  logic [IDW-1:0]       rsp_id;

  modport master (
    input  req_valid, req_x1, req_x2, div_res, div_exp1, rsp_ready,
    output req_ready, div_x1, div_x2, rsp_valid, rsp_res, rsp_exp1, rsp_id
  );

  modport slave (
    output req_valid, req_x1, req_x2, div_res, div_exp1, rsp_ready,
    input  req_ready, div_x1, div_x2, rsp_valid, rsp_res, rsp_exp1, rsp_id
  );
endinterface

// File: rtl/plad_div_arbiter.sv
// Round-robin arbiter sharing one combinational PLAD divider among NREQ requesters.
// Optional PLAD_ARB_PERF_CNT_EN adds saturating completion/stall counters.
module plad_div_arbiter #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  plad_div_arbiter_if.master  bus
`ifdef PLAD_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [SIZE-1:0] div_x1_q, div_x1_d;
  logic [SIZE-1:0] div_x2_q, div_x2_d;
  logic [SIZE-1:0] rsp_res_q, rsp_res_d;
  logic            rsp_exp1_q, rsp_exp1_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] req_ready;

  // Circular priority search starting at rr_ptr; first asserted requester wins.
  always_comb begin
    int unsigned     cand;
    logic [IDW-1:0]  cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    div_x1_d    = div_x1_q;
    div_x2_d    = div_x2_q;
    rsp_res_d   = rsp_res_q;
    rsp_exp1_d  = rsp_exp1_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          div_x1_d = bus.req_x1[grant_idx*SIZE +: SIZE];
          div_x2_d = bus.req_x2[grant_idx*SIZE +: SIZE];
          id_d     = grant_idx;
          state_d  = StIssue;
        end
      end
      // Divider is purely combinational; this cycle lets its inputs settle.
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        rsp_res_d   = bus.div_res;
        rsp_exp1_d  = bus.div_exp1;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      div_x1_q    <= '0;
      div_x2_q    <= '0;
      rsp_res_q   <= '0;
      rsp_exp1_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      div_x1_q    <= div_x1_d;
      div_x2_q    <= div_x2_d;
      rsp_res_q   <= rsp_res_d;
      rsp_exp1_q  <= rsp_exp1_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.div_x1    = div_x1_q;
  assign bus.div_x2    = div_x2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_exp1  = rsp_exp1_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef PLAD_ARB_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_cnt_d  = perf_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rsp_valid_q && bus.rsp_ready && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
    if ((state_q == StResp) && !bus.rsp_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      perf_cnt_q  <= perf_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_cnt  = perf_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_plad_div_arbiter.sv
// Directed self-checking bench for plad_div_arbiter with a stand-in combinational divider.
module tb_plad_div_arbiter;
  localparam int SIZE = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  plad_div_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef PLAD_ARB_PERF_CNT_EN
  logic [31:0] perf_cnt;
  logic [31:0] stall_cnt;
`endif

  plad_div_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef PLAD_ARB_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Stand-in for the divider: any deterministic function of the operands will do.
  function automatic logic [15:0] div_model(input logic [15:0] a, input logic [15:0] b);
    return (a ^ {b[7:0], b[15:8]}) + 16'd3;
  endfunction

  assign bus.div_res  = div_model(bus.div_x1, bus.div_x2);
  assign bus.div_exp1 = (bus.div_x1 >= bus.div_x2);

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_x1 = '0;
    bus.req_x2 = '0;
    step();
    step();
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    total++; if (bus.div_x1 !== 16'h0) begin bad++; $display("FAIL reset_div_x1 got %h want 0000", bus.div_x1); end
    total++; if (bus.div_x2 !== 16'h0) begin bad++; $display("FAIL reset_div_x2 got %h want 0000", bus.div_x2); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_res !== 16'h0) begin bad++; $display("FAIL reset_rsp_res got %h want 0000", bus.rsp_res); end
    total++; if (bus.rsp_exp1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_exp1 got %b want 0", bus.rsp_exp1); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
`ifdef PLAD_ARB_PERF_CNT_EN
    total++; if (perf_cnt !== 32'd0) begin bad++; $display("FAIL reset_perf_cnt got %0d want 0", perf_cnt); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL idle_req_ready cyc %0d got %b want 0000", i, bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_rsp_valid cyc %0d got %b want 0", i, bus.rsp_valid); end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_x1 = '0;
    bus.req_x2 = '0;
    bus.req_x1[2*SIZE +: SIZE] = 16'h4000;
    bus.req_x2[2*SIZE +: SIZE] = 16'h4000;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got %b want 0100", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    #1;
    total++; if (bus.div_x1 !== 16'h4000) begin bad++; $display("FAIL single_div_x1 got %h want 4000", bus.div_x1); end
    total++; if (bus.div_x2 !== 16'h4000) begin bad++; $display("FAIL single_div_x2 got %h want 4000", bus.div_x2); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_issue_ready got %b want 0000", bus.req_ready); end
    step();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got %b want 0", bus.rsp_valid); end
    step();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got %b want 1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp_id got %0d want 2", bus.rsp_id); end
    total++; if (bus.rsp_res !== 16'h4043) begin bad++; $display("FAIL single_rsp_res got %h want 4043", bus.rsp_res); end
    total++; if (bus.rsp_exp1 !== 1'b1) begin bad++; $display("FAIL single_rsp_exp1 got %b want 1", bus.rsp_exp1); end
    step();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_res !== 16'h4043) begin bad++; $display("FAIL single_res_hold got %h want 4043", bus.rsp_res); end
    total++; if (bus.div_x1 !== 16'h4000) begin bad++; $display("FAIL single_x1_hold got %h want 4000", bus.div_x1); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  want_ready;
    logic [15:0] a;
    logic [15:0] b;
    int          who;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x1[i*SIZE +: SIZE] = 16'(16'h1100 * (i + 1) + 16'h0007);
      bus.req_x2[i*SIZE +: SIZE] = 16'(16'h0230 + i);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      who = k % NREQ;
      want_ready = 4'(1 << who);
      a = 16'(16'h1100 * (who + 1) + 16'h0007);
      b = 16'(16'h0230 + who);
      total++; if (bus.req_ready !== want_ready) begin bad++; $display("FAIL rr_grant %0d got %b want %b", k, bus.req_ready, want_ready); end
      step();
      step();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rr_busy_ready %0d got %b want 0000", k, bus.req_ready); end
      step();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_rsp_valid %0d got %b want 1", k, bus.rsp_valid); end
      total++; if (bus.rsp_id !== 2'(who)) begin bad++; $display("FAIL rr_rsp_id %0d got %0d want %0d", k, bus.rsp_id, who); end
      total++; if (bus.rsp_res !== div_model(a, b)) begin bad++; $display("FAIL rr_rsp_res %0d got %h want %h", k, bus.rsp_res, div_model(a, b)); end
      step();
      #1;
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [15:0] res0;
    do_reset();
    bus.req_x1[0 +: SIZE] = 16'h0F0F;
    bus.req_x2[0 +: SIZE] = 16'h3C3C;
    res0 = div_model(16'h0F0F, 16'h3C3C);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant got %b want 0001", bus.req_ready); end
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc %0d got %b want 1", i, bus.rsp_valid); end
      total++; if (bus.rsp_res !== res0) begin bad++; $display("FAIL bp_res cyc %0d got %h want %h", i, bus.rsp_res, res0); end
      total++; if (bus.rsp_exp1 !== 1'b0) begin bad++; $display("FAIL bp_exp1 cyc %0d got %b want 0", i, bus.rsp_exp1); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL bp_id cyc %0d got %0d want 0", i, bus.rsp_id); end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc %0d got %b want 0000", i, bus.req_ready); end
      step();
    end
`ifdef PLAD_ARB_PERF_CNT_EN
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL bp_stall_cnt got %0d want 5", stall_cnt); end
    total++; if (perf_cnt !== 32'd0) begin bad++; $display("FAIL bp_perf_cnt_pre got %0d want 0", perf_cnt); end
`endif
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held got %b want 1", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    step();
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got %b want 0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got %b want 0010", bus.req_ready); end
`ifdef PLAD_ARB_PERF_CNT_EN
    total++; if (perf_cnt !== 32'd1) begin bad++; $display("FAIL bp_perf_cnt got %0d want 1", perf_cnt); end
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL bp_stall_hold got %0d want 5", stall_cnt); end
`endif
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_x1[0 +: SIZE] = 16'h1234;
    bus.req_x2[0 +: SIZE] = 16'h0042;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_grant got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.div_x1 !== 16'h0) begin bad++; $display("FAIL mid_div_x1 got %h want 0000", bus.div_x1); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_rst got %b want 0", bus.rsp_valid); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp cyc %0d got %b want 0", i, bus.rsp_valid); end
    end
    bus.req_valid = 4'b0011;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_regrant got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_withdrawal();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wd_grant got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    step();
    step();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL wd_rsp_valid got %b want 1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL wd_rsp_id got %0d want 0", bus.rsp_id); end
    bus.req_valid = 4'b0010;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL wd_ready_resp got %b want 0000", bus.req_ready); end
    step();
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL wd_ready_resp2 got %b want 0000", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    step();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wd_no_rsp cyc %0d got %b want 0", i, bus.rsp_valid); end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL wd_no_grant cyc %0d got %b want 0000", i, bus.req_ready); end
    end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL wd_id_hold got %0d want 0", bus.rsp_id); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_x1 = '0;
    bus.req_x2 = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_withdrawal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
